dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and a debug/DMA loader port (DBG port).
- CPU has fixed priority. A starvation counter guarantees the DBG port one slot after MAX_WAIT consecutive denied cycles.
- Sits between the MEM stage and the data memory. Drives the memory's address, write-enable, read-enable and write-data inputs.
- Returns read data to whichever port issued the read, and stalls the pipeline whenever the CPU loses a cycle.

Parameters:
- AW, 8, memory address width (256 words).
- DW, 32, data width.
- MAX_WAIT, 4, consecutive denied DBG cycles before DBG is forced a grant (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- cpu_req  in  1  CPU access request (MemRead or MemWrite active).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  DW  CPU store data.
- cpu_stall  out  1  CPU request not serviced this cycle; pipeline must hold.
- cpu_rdata  out  DW  CPU load data.
- cpu_rvalid  out  1  cpu_rdata valid.
- dbg_req  in  1  DBG access request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  AW  DBG word address.
- dbg_wdata  in  DW  DBG write data.
- dbg_gnt  out  1  DBG request accepted this cycle.
- dbg_rdata  out  DW  DBG read data.
- dbg_rvalid  out  1  dbg_rdata valid.
- mem_addr  out  AW  to memory address.
- mem_write  out  1  to memory write enable.
- mem_read  out  1  to memory read enable.
- mem_wdata  out  DW  to memory write data.
- mem_rdata  in  DW  from memory read data; valid at the posedge one cycle after mem_read.

Behaviour:
- State machine: `owner_q` ∈ {IDLE, CPU, DBG}, the owner of the previous cycle. It is used only for read-data routing and observability.
- Grant decision, combinational each cycle:
  - `force` = (`wait_cnt` == MAX_WAIT).
  - If `dbg_req` && (`force` || !`cpu_req`), DBG wins.
  - Else if `cpu_req`, CPU wins.
  - Else IDLE.
- Outputs from the grant decision:
  - `dbg_gnt` = DBG wins.
  - `cpu_stall` = `cpu_req` && !CPU wins.
- Memory drive, combinational mux of the winner:
  - `mem_write` = winner's `we`; `mem_read` = !winner's `we`.
  - `mem_addr` and `mem_wdata` come from the winner.
  - With no winner: `mem_write` = `mem_read` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Starvation counter `wait_cnt`, 4-bit:
  - Increments each cycle `dbg_req` && !`dbg_gnt`.
  - Clears on `dbg_gnt` or when !`dbg_req`.
  - Never exceeds MAX_WAIT.
- Read return, 1-cycle latency:
  - Registered `rd_owner_q` captures the winner when `mem_read` = 1, else NONE.
  - Next cycle, `cpu_rvalid` = (`rd_owner_q` == CPU) and `dbg_rvalid` = (`rd_owner_q` == DBG).
  - The corresponding rdata = `mem_rdata`; the other rdata holds its last value.
  - Writes produce no rvalid.
- Back-to-back accesses are allowed every cycle. A read followed by a write to the same address returns the pre-write data.
- Simultaneous `cpu_req` + `dbg_req` with `force` = 0: CPU wins, `dbg_gnt` = 0, `wait_cnt` increments.
- `force` = 1: DBG wins; `cpu_stall` = 1 for exactly that cycle; the CPU is serviced the next cycle if still requesting.
- A request may change address/data while stalled. The arbiter samples only in the granted cycle.
- Reset, synchronous, `rst_n` = 0 at posedge:
  - `owner_q` = IDLE, `wait_cnt` = 0, `rd_owner_q` = NONE.
  - `cpu_rvalid` = `dbg_rvalid` = 0; `cpu_rdata` = `dbg_rdata` = 0.
  - While `rst_n` = 0, all mem_* outputs = 0, `dbg_gnt` = 0, `cpu_stall` = 0.
  - A read granted in the cycle before reset asserts produces no rvalid.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds output `stall_cnt` [15:0]: counts cycles with `cpu_stall` = 1.
  - Adds output `force_cnt` [15:0]: counts forced DBG grants.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold `rst_n` = 0 for 2 cycles with both requests high -> all mem_* = 0, `dbg_gnt` = 0, `cpu_stall` = 0, rvalids = 0.
- CPU-only write then read:
  - Stimulus: cycle 0 write addr 8'h10 data 32'hDEADBEEF; cycle 1 read addr 8'h10.
  - Response: `mem_write` = 1 in cycle 0, `mem_read` = 1 in cycle 1; `cpu_rvalid` = 1 with `cpu_rdata` = 32'hDEADBEEF in cycle 2; `cpu_stall` never 1.
- DBG-only read of addr 8'h20 preloaded with 32'h12345678 -> `dbg_gnt` = 1 same cycle; `dbg_rvalid` = 1, `dbg_rdata` = 32'h12345678 next cycle.
- Contention with MAX_WAIT = 4:
  - Stimulus: `cpu_req` and `dbg_req` both held high.
  - Response: CPU granted cycles 0–3; DBG granted cycle 4 with `cpu_stall` = 1 only in cycle 4; `wait_cnt` returns to 0; pattern repeats every 5 cycles.
- Mid-read reset: DBG read granted, `rst_n` = 0 the next posedge -> `dbg_rvalid` stays 0; after release, a fresh CPU read returns correct data with 1-cycle latency.
- With DMEM_ARB_STATS_EN, 20 cycles of the contention pattern -> `stall_cnt` = 4, `force_cnt` = 4.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DBG data-memory arbiter with DBG starvation guard (optional stats: DMEM_ARB_STATS_EN)
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_rvalid,

    output logic [AW-1:0] mem_addr,
    output logic          mem_write,
    output logic          mem_read,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stall_cnt,
    output logic [15:0]   force_cnt
`endif
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    owner_e        owner_q, owner_d;
    owner_e        rd_owner;
    logic          rd_pend_q, rd_pend_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          force_grant;
    logic          cpu_win;
    logic          dbg_win;

    // Grant decision: CPU first unless DBG has waited MAX_WAIT cycles; everything gated off in reset
    always_comb begin
        force_grant = (wait_cnt_q == MAX_W);
        dbg_win     = rst_n && dbg_req && (force_grant || !cpu_req);
        cpu_win     = rst_n && cpu_req && !dbg_win;
        dbg_gnt     = dbg_win;
        cpu_stall   = rst_n && cpu_req && !cpu_win;
        owner_d     = dbg_win ? OWN_DBG : (cpu_win ? OWN_CPU : OWN_NONE);
    end

    // Memory drive: mux the winner's request, all zero when nobody owns the cycle
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (dbg_win) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_write = dbg_we;
            mem_read  = !dbg_we;
        end else if (cpu_win) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_write = cpu_we;
            mem_read  = !cpu_we;
        end
    end

    // Starvation counter: counts denied DBG cycles, cleared on grant or when DBG drops its request
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dbg_req || dbg_win) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < MAX_W) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // Read return: the previous cycle's owner gets mem_rdata if that cycle was a read
    always_comb begin
        rd_pend_d   = mem_read;
        rd_owner    = rd_pend_q ? owner_q : OWN_NONE;
        cpu_rvalid  = rst_n && (rd_owner == OWN_CPU);
        dbg_rvalid  = rst_n && (rd_owner == OWN_DBG);
        cpu_rdata_d = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        dbg_rdata_d = dbg_rvalid ? mem_rdata : dbg_rdata_q;
        cpu_rdata   = cpu_rdata_d;
        dbg_rdata   = dbg_rdata_d;
    end

    // Owner FSM, starvation counter and read-data hold registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q     <= OWN_NONE;
            rd_pend_q   <= 1'b0;
            wait_cnt_q  <= 4'd0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            rd_pend_q   <= rd_pend_d;
            wait_cnt_q  <= wait_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] force_cnt_q, force_cnt_d;

    // Saturating counters of CPU stall cycles and forced DBG grants
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        force_cnt_d = force_cnt_q;
        if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (dbg_win && force_grant && (force_cnt_q != 16'hFFFF)) begin
            force_cnt_d = force_cnt_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            force_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            force_cnt_q <= force_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign force_cnt = force_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        dbg_req, dbg_we;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;
    logic [7:0]  mem_addr;
    logic        mem_write, mem_read;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt, force_cnt;
`endif

    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] mem [256];

    int n_assert = 0;
    int n_fail   = 0;

    dmem_arbiter #(.AW(8), .DW(32), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rdata  (dbg_rdata),
        .dbg_rvalid (dbg_rvalid),
        .mem_addr   (mem_addr),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .force_cnt  (force_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory model with a side-door preload path
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 32'h0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 32'h0;
        ld_en = 1'b1; ld_addr = 8'h20; ld_data = 32'h12345678;
        mem_rdata = 32'h0;

        // Reset held two cycles with both requests high
        tick();
        ld_addr = 8'h40; ld_data = 32'h11111111;
        @(negedge clk);
        chk("rst_mem_read",   32'(mem_read),   32'd0);
        chk("rst_mem_write",  32'(mem_write),  32'd0);
        chk("rst_mem_addr",   32'(mem_addr),   32'd0);
        chk("rst_mem_wdata",  mem_wdata,       32'd0);
        chk("rst_dbg_gnt",    32'(dbg_gnt),    32'd0);
        chk("rst_cpu_stall",  32'(cpu_stall),  32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst_cpu_rdata",  cpu_rdata,       32'd0);
        chk("rst_dbg_rdata",  dbg_rdata,       32'd0);
        tick();
        ld_en = 1'b0;
        rst_n = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0;

        // CPU write 0x10 then read it back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("cw_mem_write", 32'(mem_write), 32'd1);
        chk("cw_mem_read",  32'(mem_read),  32'd0);
        chk("cw_mem_addr",  32'(mem_addr),  32'h10);
        chk("cw_mem_wdata", mem_wdata,      32'hDEADBEEF);
        chk("cw_stall",     32'(cpu_stall), 32'd0);
        tick();
        cpu_we = 1'b0;
        @(negedge clk);
        chk("cr_mem_read",  32'(mem_read),   32'd1);
        chk("cr_mem_write", 32'(mem_write),  32'd0);
        chk("cr_stall",     32'(cpu_stall),  32'd0);
        chk("cr_rvalid_c1", 32'(cpu_rvalid), 32'd0);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("cr_rvalid_c2", 32'(cpu_rvalid), 32'd1);
        chk("cr_rdata_c2",  cpu_rdata,       32'hDEADBEEF);
        chk("cr_dbg_rv",    32'(dbg_rvalid), 32'd0);
        tick();

        // DBG-only read of preloaded 0x20
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
        @(negedge clk);
        chk("dr_gnt",      32'(dbg_gnt),   32'd1);
        chk("dr_mem_read", 32'(mem_read),  32'd1);
        chk("dr_mem_addr", 32'(mem_addr),  32'h20);
        chk("dr_stall",    32'(cpu_stall), 32'd0);
        tick();
        dbg_req = 1'b0;
        @(negedge clk);
        chk("dr_rvalid",     32'(dbg_rvalid), 32'd1);
        chk("dr_rdata",      dbg_rdata,       32'h12345678);
        chk("dr_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("dr_cpu_hold",   cpu_rdata,       32'hDEADBEEF);
        tick();

        // Read followed by write to the same address returns pre-write data
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40;
        tick();
        cpu_we = 1'b1; cpu_wdata = 32'h22222222;
        @(negedge clk);
        chk("rw_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rw_rdata",  cpu_rdata,       32'h11111111);
        chk("rw_write",  32'(mem_write),  32'd1);
        tick();
        cpu_we = 1'b0;
        @(negedge clk);
        chk("rw_no_rv_after_wr", 32'(cpu_rvalid), 32'd0);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rw_new_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rw_new_rdata",  cpu_rdata,       32'h22222222);
        tick();

        // Contention: both write continuously, DBG forced in every fifth cycle
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 32'hC0DE0030;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h31; dbg_wdata = 32'h00000031;
        for (int i = 0; i < 20; i++) begin
            automatic logic exp_dbg = ((i % 5) == 4);
            @(negedge clk);
            chk($sformatf("ct%0d_gnt", i),   32'(dbg_gnt),   32'(exp_dbg));
            chk($sformatf("ct%0d_stall", i), 32'(cpu_stall), 32'(exp_dbg));
            chk($sformatf("ct%0d_addr", i),  32'(mem_addr),  exp_dbg ? 32'h31 : 32'h30);
            chk($sformatf("ct%0d_wdata", i), mem_wdata,      exp_dbg ? 32'h00000031 : 32'hC0DE0030);
            tick();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
`ifdef DMEM_ARB_STATS_EN
        @(negedge clk);
        chk("stat_stall_cnt", 32'(stall_cnt), 32'd4);
        chk("stat_force_cnt", 32'(force_cnt), 32'd4);
`endif

        // Both ports' contention writes landed
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
        tick();
        cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h31;
        @(negedge clk);
        chk("vb_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("vb_cpu_rdata",  cpu_rdata,       32'hC0DE0030);
        chk("vb_dbg_gnt",    32'(dbg_gnt),    32'd1);
        tick();
        dbg_req = 1'b0;
        @(negedge clk);
        chk("vb_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("vb_dbg_rdata",  dbg_rdata,       32'h00000031);
        tick();

        // Mid-read reset: granted DBG read must not return data
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
        @(negedge clk);
        chk("mr_gnt", 32'(dbg_gnt), 32'd1);
        tick();
        dbg_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("mr_rvalid_in_rst", 32'(dbg_rvalid), 32'd0);
        chk("mr_mem_read_rst",  32'(mem_read),   32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rvalid_after", 32'(dbg_rvalid), 32'd0);
        chk("mr_dbg_rdata",    dbg_rdata,       32'd0);
        chk("mr_cpu_rdata",    cpu_rdata,       32'd0);
`ifdef DMEM_ARB_STATS_EN
        chk("mr_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("mr_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("mr_cpu_rdata2", cpu_rdata,       32'hDEADBEEF);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
